// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the two-master SDRAM front-end arbiter and its read-tag FIFO.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Tag FIFO recording which master owns each outstanding read, oldest at head.
module sdram_tag_fifo
  import sdram_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  master_id_t             push_tag,
  input  logic                   pop,
  output master_id_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  master_id_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter merging two Avalon-MM pipelined-read masters onto one
// SDRAM controller port; read returns are steered back by an in-order tag FIFO.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  output logic                m0_waitrequest,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  output logic                m1_waitrequest,
  output logic                m1_readdatavalid,
  output logic [DATA_W-1:0]   m_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  input  logic                s_waitrequest,
  input  logic                s_readdatavalid,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic                err_orphan,
  output arb_state_t          dbg_state
);

  localparam int CW = $clog2(MAX_PEND) + 1;

  arb_state_t    state;
  master_id_t    rr_last;
  master_id_t    gnt_id;
  master_id_t    fifo_head;
  logic [CW-1:0] pend_count;
  logic          fifo_empty;
  logic          read_blocked;
  logic          m0_req, m1_req, other_req;
  logic          g_read, g_write, g_req, g_eff;
  logic          accept, ret_pop, err_q;
  arb_state_t    other_state;

  assign m0_req       = m0_read | m0_write;
  assign m1_req       = m1_read | m1_write;
  assign read_blocked = (pend_count == CW'(MAX_PEND));
  assign gnt_id       = master_id_t'(state == G1);
  assign other_state  = (state == G0) ? G1 : G0;
  assign other_req    = (state == G0) ? m1_req : m0_req;

  // A strobe pair with both bits set is a write; read only when write is low.
  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    g_read       = 1'b0;
    g_write      = 1'b0;
    case (state)
      G0: begin
        s_address    = m0_address;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        g_write      = m0_write;
        g_read       = m0_read & ~m0_write;
      end
      G1: begin
        s_address    = m1_address;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        g_write      = m1_write;
        g_read       = m1_read & ~m1_write;
      end
      default: ;
    endcase
  end

  assign g_req   = g_read | g_write;
  assign g_eff   = g_write | (g_read & ~read_blocked);
  assign s_write = g_write & ~reset;
  assign s_read  = g_read & ~read_blocked & ~reset;

  // Handshake: a transfer completes on a cycle where the master strobe is high
  // and its waitrequest is low; the slave side likewise on strobe & !s_waitrequest.
  assign accept         = (s_read | s_write) & ~s_waitrequest;
  assign m0_waitrequest = reset | (state != G0) | s_waitrequest | (g_read & read_blocked);
  assign m1_waitrequest = reset | (state != G1) | s_waitrequest | (g_read & read_blocked);

  // A granted master parked on a blocked read yields to the other master.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req && m1_req) state <= (rr_last == 1'b1) ? G0 : G1;
          else if (m0_req)      state <= G0;
          else if (m1_req)      state <= G1;
        end
        default: begin
          if (accept) begin
            rr_last <= gnt_id;
            if (other_req)   state <= other_state;
            else if (!g_req) state <= IDLE;
          end else if (!g_eff && other_req) begin
            state <= other_state;
          end else if (!g_req) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign ret_pop = s_readdatavalid & ~fifo_empty;

  sdram_tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept & s_read),
    .push_tag (gnt_id),
    .pop      (ret_pop),
    .head     (fifo_head),
    .count    (pend_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)                               err_q <= 1'b0;
    else if (s_readdatavalid && fifo_empty)  err_q <= 1'b1;
  end

  assign m_readdata       = s_readdata;
  assign m0_readdatavalid = ret_pop & (fifo_head == 1'b0) & ~reset;
  assign m1_readdatavalid = ret_pop & (fifo_head == 1'b1) & ~reset;
  assign err_orphan       = err_q & ~reset;
  assign dbg_state        = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed plus randomized bench for sdram_arbiter with a queue-based model of
// read ownership, acceptance ordering and the orphan flag.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int MAX_PEND = 8;
  localparam int BE_W     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic              m0_waitrequest, m1_waitrequest;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m_readdata;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_read, s_write;
  logic              s_waitrequest, s_readdatavalid;
  logic [DATA_W-1:0] s_readdata;
  logic              err_orphan;
  arb_state_t        dbg_state;

  int n_chk = 0;
  int n_err = 0;

  logic [0:0] exp_q[$];      // owners of outstanding reads, oldest first
  logic [0:0] act_log[$];    // readdatavalid pulses as observed
  logic [0:0] grant_log[$];  // masters whose transfer completed
  logic       orphan_m = 1'b0;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m_readdata(m_readdata),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
    .err_orphan(err_orphan), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '1; m1_byteenable = '1;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic drive(input int id, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
  endtask

  // Hold one request until the master sees waitrequest low, bounded.
  task automatic do_req(input int id, input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic done;
    done = 1'b0;
    drive(id, rd, wr, a, d);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = (id == 0) ? !m0_waitrequest : !m1_waitrequest;
      tick();
    end
    drive(id, 1'b0, 1'b0, a, d);
    chk($sformatf("req_done_m%0d", id), 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      s_readdatavalid = 1'b1;
      s_readdata      = DATA_W'($urandom);
      @(negedge clk);
      tick();
    end
    s_readdatavalid = 1'b0;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard / reference model ----------------
  always @(negedge clk) begin
    logic       acc0, acc1, exp0, exp1, hd;
    int         pend_before;
    if (reset) begin
      chk("rst_s_read", 32'(s_read), 32'd0);
      chk("rst_s_write", 32'(s_write), 32'd0);
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
      chk("rst_orphan", 32'(err_orphan), 32'd0);
      exp_q.delete();
      orphan_m = 1'b0;
    end else begin
      chk("err_orphan", 32'(err_orphan), 32'(orphan_m));
      chk("readdata_pass", 32'(m_readdata), 32'(s_readdata));
      pend_before = exp_q.size();
      exp0 = 1'b0;
      exp1 = 1'b0;
      if (s_readdatavalid) begin
        if (exp_q.size() > 0) begin
          hd = exp_q.pop_front();
          if (hd == 1'b0) exp0 = 1'b1; else exp1 = 1'b1;
        end else begin
          orphan_m = 1'b1;
        end
      end
      chk("m0_rdv", 32'(m0_readdatavalid), 32'(exp0));
      chk("m1_rdv", 32'(m1_readdatavalid), 32'(exp1));
      if (m0_readdatavalid) act_log.push_back(1'b0);
      if (m1_readdatavalid) act_log.push_back(1'b1);

      acc0 = (m0_read | m0_write) && !m0_waitrequest;
      acc1 = (m1_read | m1_write) && !m1_waitrequest;
      chk("one_grant", 32'(acc0 & acc1), 32'd0);
      if ((s_read | s_write) && !s_waitrequest)
        chk("slave_acc_has_master", 32'(acc0 | acc1), 32'd1);
      if (acc0) begin
        chk("acc0_addr", 32'(s_address), 32'(m0_address));
        chk("acc0_kind", 32'({s_write, s_read}), 32'({m0_write, m0_read & ~m0_write}));
        if (m0_write) chk("acc0_wdata", 32'({s_byteenable, s_writedata}), 32'({m0_byteenable, m0_writedata}));
        if (!m0_write) begin
          chk("acc0_not_full", 32'(pend_before < MAX_PEND), 32'd1);
          exp_q.push_back(1'b0);
        end
        grant_log.push_back(1'b0);
      end
      if (acc1) begin
        chk("acc1_addr", 32'(s_address), 32'(m1_address));
        chk("acc1_kind", 32'({s_write, s_read}), 32'({m1_write, m1_read & ~m1_write}));
        if (m1_write) chk("acc1_wdata", 32'({s_byteenable, s_writedata}), 32'({m1_byteenable, m1_writedata}));
        if (!m1_write) begin
          chk("acc1_not_full", 32'(pend_before < MAX_PEND), 32'd1);
          exp_q.push_back(1'b1);
        end
        grant_log.push_back(1'b1);
      end
    end
  end

  // ---------------- directed and random steps ----------------
  initial begin
    logic m1_acc, hold0, hold1;
    logic [1:0] k;

    reset = 1'b1;
    idle_inputs();
    reset_dut();
    @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_orphan", 32'(err_orphan), 32'd0);
    tick();

    // Single read from m0, return three cycles later.
    act_log.delete();
    do_req(0, 1'b1, 1'b0, 25'h0001234, '0);
    repeat (2) tick();
    s_readdatavalid = 1'b1;
    s_readdata      = 16'hBEEF;
    @(negedge clk);
    chk("single_rd_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    chk("single_rd_data", 32'(m_readdata), 32'hBEEF);
    tick();
    s_readdatavalid = 1'b0;
    repeat (3) tick();
    chk("single_rd_pulses", 32'(act_log.size()), 32'd1);
    chk("single_rd_owner", 32'(act_log[0]), 32'd0);

    // Contention: continuous writes from both masters straight out of reset.
    reset_dut();
    grant_log.delete();
    drive(0, 1'b0, 1'b1, 25'h0000100, 16'h1111);
    drive(1, 1'b0, 1'b1, 25'h0000200, 16'h2222);
    repeat (11) tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    chk("contend_count", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < grant_log.size(); i++)
      chk($sformatf("contend_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));
    repeat (2) tick();

    // Interleaved returns: accept m1, m0, m0, then return later.
    act_log.delete();
    do_req(1, 1'b1, 1'b0, 25'h0000A00, '0);
    do_req(0, 1'b1, 1'b0, 25'h0000B00, '0);
    do_req(0, 1'b1, 1'b0, 25'h0000B01, '0);
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      s_readdatavalid = 1'b1;
      s_readdata      = DATA_W'(16'h5000 + i);
      @(negedge clk);
      tick();
    end
    s_readdatavalid = 1'b0;
    chk("interleave_count", 32'(act_log.size()), 32'd3);
    chk("interleave_0", 32'(act_log[0]), 32'd1);
    chk("interleave_1", 32'(act_log[1]), 32'd0);
    chk("interleave_2", 32'(act_log[2]), 32'd0);

    // Full tag FIFO: ninth read is held while a write from m1 still goes through.
    for (int i = 0; i < MAX_PEND; i++) do_req(0, 1'b1, 1'b0, ADDR_W'(32'h300 + i), '0);
    drive(0, 1'b1, 1'b0, 25'h0000399, '0);
    drive(1, 1'b0, 1'b1, 25'h0000400, 16'hCAFE);
    m1_acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("full_s_read", 32'(s_read), 32'd0);
      if (!m1_waitrequest) m1_acc = 1'b1;
      tick();
      if (m1_acc) drive(1, 1'b0, 1'b0, '0, '0);
    end
    chk("full_write_accepted", 32'(m1_acc), 32'd1);
    s_readdatavalid = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle_wait", 32'(m0_waitrequest), 32'd1);
    chk("full_pop_cycle_s_read", 32'(s_read), 32'd0);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("unblock_s_read", 32'(s_read), 32'd1);
    chk("unblock_m0_wait", 32'(m0_waitrequest), 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drain();

    // Stall: slave waitrequest high for four cycles while G0 holds.
    reset_dut();
    s_waitrequest = 1'b1;
    drive(0, 1'b0, 1'b1, 25'h0000777, 16'h7777);
    drive(1, 1'b0, 1'b1, 25'h0000888, 16'h8888);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_state", 32'(dbg_state), 32'(G0));
      chk("stall_addr", 32'(s_address), 32'h777);
      chk("stall_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("stall_m1_wait", 32'(m1_waitrequest), 32'd1);
      tick();
    end
    s_waitrequest = 1'b0;
    @(negedge clk);
    chk("stall_release_m0", 32'(m0_waitrequest), 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("stall_next_grant", 32'(dbg_state), 32'(G1));
    chk("stall_m1_go", 32'(m1_waitrequest), 32'd0);
    tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    // Orphan: a read in flight across reset, then its return arrives.
    do_req(1, 1'b1, 1'b0, 25'h0000123, '0);
    reset_dut();
    s_readdatavalid = 1'b1;
    @(negedge clk);
    chk("orphan_no_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("orphan_set", 32'(err_orphan), 32'd1);
    repeat (3) tick();
    chk("orphan_sticky", 32'(err_orphan), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("orphan_in_reset", 32'(err_orphan), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("orphan_cleared", 32'(err_orphan), 32'd0);
    chk("orphan_state_idle", 32'(dbg_state), 32'(IDLE));
    tick();

    // Randomized traffic under Avalon hold rules; the scoreboard checks routing.
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold0) begin
        k = 2'($urandom_range(0, 3));
        drive(0, k[0], k[1], ADDR_W'($urandom), DATA_W'($urandom));
        m0_byteenable = BE_W'($urandom);
      end
      if (!hold1) begin
        k = 2'($urandom_range(0, 3));
        drive(1, k[0], k[1], ADDR_W'($urandom), DATA_W'($urandom));
        m1_byteenable = BE_W'($urandom);
      end
      s_waitrequest   = ($urandom_range(0, 3) == 0);
      s_readdatavalid = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      s_readdata      = DATA_W'($urandom);
      @(negedge clk);
      hold0 = (m0_read | m0_write) && m0_waitrequest;
      hold1 = (m1_read | m1_write) && m1_waitrequest;
      tick();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    s_waitrequest = 1'b0;
    drain();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
